// File: rtl/uc_secuenciador.sv
// Control unit for the 8-bit single-cycle datapath: opcode/zero-flag decode plus a run/halt/step sequencer.
// Optional retired-instruction counter (output retired_o) is built when UC_PERFCNT_EN is defined.
module uc_secuenciador (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [5:0] opcode_i,
  input  logic       z_i,
  input  logic       start_i,
  input  logic       dbg_halt_i,
  input  logic       dbg_step_i,
  output logic       s_inc_o,
  output logic       s_inm_o,
  output logic       we3_o,
  output logic       wez_o,
  output logic [2:0] op_o,
  output logic       pc_we_o,
  output logic       running_o,
  output logic       halted_o,
  output logic       step_done_o,
`ifdef UC_PERFCNT_EN
  output logic [15:0] retired_o,
`endif
  output logic       illegal_o
);

  // state  | meaning
  // IDLE   | after reset, waiting for start
  // RUN    | executing one instruction per cycle
  // HALTED | stopped by HALT opcode or debug host
  // STEP   | executing a single debug-stepped instruction
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    STEP   = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   step_done_q, step_done_d;
  logic   illegal_q, illegal_d;
  logic   exec;
  logic   halt_op;
  logic   illegal_op;
  logic   unused_opcode_lsbs;

  assign unused_opcode_lsbs = ^opcode_i[1:0];
  assign exec = (state_q == RUN) || (state_q == STEP);

  always_comb begin
    s_inc_o    = 1'b1;
    s_inm_o    = 1'b0;
    we3_o      = 1'b0;
    wez_o      = 1'b0;
    op_o       = 3'b000;
    pc_we_o    = 1'b0;
    halt_op    = 1'b0;
    illegal_op = 1'b0;
    if (exec) begin
      pc_we_o = 1'b1;
      if (opcode_i[5]) begin
        op_o  = opcode_i[4:2];
        we3_o = 1'b1;
        wez_o = 1'b1;
      end else begin
        case (opcode_i[4:2])
          3'b000: begin
            s_inm_o = 1'b1;
            we3_o   = 1'b1;
          end
          3'b001:  s_inc_o = 1'b0;
          3'b010:  s_inc_o = ~z_i;
          3'b011:  s_inc_o = z_i;
          3'b100:  halt_op = 1'b1;
          3'b101:  ;
          default: illegal_op = 1'b1;
        endcase
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    step_done_d = (state_q == STEP);
    illegal_d   = illegal_q | illegal_op;
    case (state_q)
      IDLE: if (start_i) state_d = RUN;
      RUN:  if (halt_op || dbg_halt_i) state_d = HALTED;
      HALTED: begin
        // a step request wins over a simultaneous resume
        if (dbg_step_i)                    state_d = STEP;
        else if (start_i && !dbg_halt_i)   state_d = RUN;
      end
      STEP:    state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      step_done_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_done_q <= step_done_d;
      illegal_q   <= illegal_d;
    end
  end

  assign running_o   = (state_q == RUN);
  assign halted_o    = (state_q == HALTED);
  assign step_done_o = step_done_q;
  assign illegal_o   = illegal_q;

`ifdef UC_PERFCNT_EN
  logic [15:0] retired_q, retired_d;

  assign retired_d = exec ? retired_q + 16'd1 : retired_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) retired_q <= 16'd0;
    else         retired_q <= retired_d;
  end

  assign retired_o = retired_q;
`endif

endmodule

// File: doc/uc_secuenciador.md
# uc_secuenciador

Control unit for the single-cycle 8-bit microcontroller datapath (10-bit PC, 16-bit instructions, 6-bit opcode in instr[15:10]). It decodes the opcode and zero flag into the datapath controls: PC select, immediate select, register-file write, flag write and ALU op. It also adds a run/halt/single-step sequencer, so a debug host can stop, step and resume the program. It sits beside the datapath and is the only driver of its control inputs, plus a new PC write enable.

## Interface
- Parameters: none.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  6  instr[15:10] from the datapath.
- z  in  1  registered zero flag from the datapath.
- start  in  1  level; leaves IDLE or HALTED into RUN.
- dbg_halt  in  1  level; stop after the current instruction.
- dbg_step  in  1  one-cycle pulse; execute exactly one instruction while HALTED.
- s_inc  out  1  PC mux select: 1 = PC+1, 0 = jump target instr[9:0].
- s_inm  out  1  1 = immediate path (LI).
- we3  out  1  register-file write enable.
- wez  out  1  zero-flag write enable.
- op  out  3  ALU operation.
- pc_we  out  1  PC register load enable.
- running  out  1  state is RUN.
- halted  out  1  state is HALTED.
- step_done  out  1  registered one-cycle pulse after a stepped instruction.
- illegal  out  1  sticky flag: an undefined opcode was executed.

## Operation
- FSM states: IDLE, RUN, HALTED, STEP. All are encoded in a registered state; reset state is IDLE.
- "Execute" cycle: the state is RUN or STEP. In any other cycle the controls are forced to pc_we=0, we3=0, wez=0, s_inc=1, s_inm=0, op=000.
- Decode, in an execute cycle, is combinational from opcode and z. pc_we=1 for every opcode.
  - opcode[5]=1: ALU op. op=opcode[4:2], we3=1, wez=1, s_inm=0, s_inc=1.
  - opcode[5:2]=0000: LI. s_inm=1, op=000 (pass), we3=1, wez=0, s_inc=1.
  - 0001: J. s_inc=0.
  - 0010: JZ. s_inc = ~z.
  - 0011: JNZ. s_inc = z.
  - 0100: HALT. s_inc=1, no writes; next state HALTED.
  - 0101: NOP.
  - 0110, 0111: illegal. Executed as NOP; illegal set to 1 at the clock edge.
  - Jumps and NOP/HALT have we3=0, wez=0, op=000.
- Transitions:
  - IDLE -> RUN when start=1.
  - RUN -> HALTED on a HALT opcode or dbg_halt=1. The current instruction completes in that cycle.
  - RUN -> RUN otherwise.
  - HALTED -> STEP on dbg_step=1. Otherwise HALTED -> RUN on start=1 and dbg_halt=0.
  - STEP -> HALTED always, after exactly one instruction. step_done=1 in the following cycle.
- Priority in HALTED: dbg_step over start.
- HALT advances the PC, so a resume continues at the next instruction.
- illegal clears only on reset.

## Timing
- Reset values: state IDLE, running=0, halted=0, step_done=0, illegal=0, pc_we=0, we3=0, wez=0, s_inc=1, s_inm=0, op=000.
- Decode latency is zero cycles: the controls are valid in the same cycle as the opcode. Register, flag and PC writes happen at the next rising edge.
- start in IDLE: the first instruction executes in the cycle after start is sampled.
- dbg_halt asserted in RUN cycle N: instruction N is still written. The controls are inert from N+1, and halted=1 from N+1.
- dbg_step sampled in HALTED cycle N: one instruction executes in N+1, step_done=1 in N+2, halted=1 in N+2.
- dbg_step pulses in non-HALTED states are ignored.
- A HALT opcode and dbg_halt together give one transition to HALTED, with no duplicate effect.
- Reset asserted mid-instruction: the state returns to IDLE immediately, and all write enables drop asynchronously.

## Configuration
- UC_PERFCNT_EN defined:
  - Adds output retired [15:0]. It increments once per execute cycle, including illegal and HALT.
  - It wraps from 0xFFFF to 0x0000, resets to 0 and holds while not executing.
- UC_PERFCNT_EN undefined: no port and no counter logic.

## Test plan
- Reset, then start=1 with opcode 1_010_00 (ALU, op 010) -> running=1 next cycle; we3=1, wez=1, op=010, pc_we=1, s_inc=1.
- JZ (001000) with z=1 -> s_inc=0. With z=0 -> s_inc=1. JNZ gives the inverse.
- HALT (010000) in RUN -> pc_we=1 in that cycle; halted=1 next cycle. In HALTED, opcode ALU gives we3=0 and pc_we=0.
- While HALTED, pulse dbg_step -> exactly one cycle with pc_we=1, then step_done=1 for one cycle, then halted=1.
- Opcode 011000 -> no writes, illegal=1 and sticky across 10 further instructions; reset clears it to 0.
- With UC_PERFCNT_EN, preload the counter to 0xFFFE via 0xFFFE executes, then run 2 instructions -> retired=0x0000. Assert reset mid-run -> retired=0, state IDLE.
